// File: rtl/inst_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// inst_mem_responder_pkg
//
// Shared definitions for the instruction-memory responder slice.
//
// The global text macros are defined at the top of this file so that every
// file compiled after it sees them:
//   `WORD_LEN   - instruction / address width of the fetch interface (32)
//   `IMR_IDLE   - FSM encoding of the idle state            (2'b00)
//   `IMR_WAIT   - FSM encoding of the wait-state countdown  (2'b01)
//   `IMR_RESP   - FSM encoding of the response-holding state (2'b10)
//
// The package wraps those encodings in a typed enum and provides the address
// error check shared by the responder.
// -----------------------------------------------------------------------------
`ifndef IMR_DEFINES_SVH
`define IMR_DEFINES_SVH
`define WORD_LEN 32
`define IMR_IDLE 2'b00
`define IMR_WAIT 2'b01
`define IMR_RESP 2'b10
`endif

package inst_mem_responder_pkg;

    // Responder FSM states; encodings come from the shared defines.
    typedef enum logic [1:0] {
        ST_IDLE = `IMR_IDLE,
        ST_WAIT = `IMR_WAIT,
        ST_RESP = `IMR_RESP
    } imrState_e;

    // Width of one instruction word.
    localparam int unsigned INSTR_W = `WORD_LEN;

    // Instruction value returned for a faulting fetch.
    localparam logic [`WORD_LEN-1:0] ERR_INSTR = {`WORD_LEN{1'b0}};

    // A fetch address is bad when it is not word aligned or when its word
    // index lies outside a memory of 'depth' words.
    function automatic logic addrErr(
        input logic [`WORD_LEN-1:0] addr,
        input int unsigned          depth
    );
        logic misaligned_s;
        logic outOfRange_s;
        misaligned_s = (addr[1:0] != 2'b00);
        outOfRange_s = ({2'b00, addr[`WORD_LEN-1:2]} >= depth);
        return misaligned_s | outOfRange_s;
    endfunction

endpackage : inst_mem_responder_pkg

// File: rtl/inst_rom.sv
// -----------------------------------------------------------------------------
// inst_rom
//
// DEPTH x WIDTH instruction storage with one synchronous write port used for
// preloading and one asynchronous read port. Contents are never cleared by
// reset; a write and a read of the same word in the same cycle return the
// old contents on the read port until the write edge has passed.
//
// Ports:
//   clk     in   write clock
//   wrEn    in   preload write enable
//   wrAddr  in   preload word index
//   wrData  in   preload data
//   rdAddr  in   read word index
//   rdData  out  asynchronous read data
// -----------------------------------------------------------------------------
module inst_rom
    import inst_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned WIDTH = INSTR_W
) (
    input  logic                     clk,
    input  logic                     wrEn,
    input  logic [$clog2(DEPTH)-1:0] wrAddr,
    input  logic [WIDTH-1:0]         wrData,
    input  logic [$clog2(DEPTH)-1:0] rdAddr,
    output logic [WIDTH-1:0]         rdData
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Preload write port; storage has no reset on purpose.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem_r[wrAddr] <= wrData;
        end
    end

    // Asynchronous read; the responder registers this value.
    assign rdData = mem_r[rdAddr];

endmodule : inst_rom

// File: rtl/inst_mem_responder.sv
// -----------------------------------------------------------------------------
// inst_mem_responder
//
// Word-addressed instruction memory that answers instruction-fetch requests
// over valid/ready handshakes, with WAIT_STATES extra cycles of latency,
// address error reporting and branch-flush abort.
//
// Parameters:
//   DEPTH        memory size in 32-bit words (power of two)
//   WAIT_STATES  extra cycles between acceptance and response (0 allowed)
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active low
//   req_valid  in   fetch request present
//   req_ready  out  responder idle and able to take a request
//   req_addr   in   byte address of the instruction
//   flush      in   branch taken; abort in-flight request
//   rsp_valid  out  response present
//   rsp_ready  in   fetch side accepts the response
//   rsp_instr  out  fetched instruction, zero on error
//   rsp_addr   out  byte address the response belongs to
//   rsp_err    out  address misaligned or out of range
//   ld_en      in   preload write enable
//   ld_addr    in   preload word index
//   ld_data    in   preload data
//
// Timing summary: a request sampled on edge N produces rsp_valid from edge
// N+WAIT_STATES (error requests from edge N). All outputs are registers.
// -----------------------------------------------------------------------------
module inst_mem_responder
    import inst_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [`WORD_LEN-1:0]     req_addr,
    input  logic                     flush,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [`WORD_LEN-1:0]     rsp_instr,
    output logic [`WORD_LEN-1:0]     rsp_addr,
    output logic                     rsp_err,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [`WORD_LEN-1:0]     ld_data
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    // Counter must hold WAIT_STATES; keep at least one bit when it is 0 or 1.
    localparam int unsigned CNT_W  = (WAIT_STATES < 32'd2) ? 1 : $clog2(WAIT_STATES + 32'd1);

    imrState_e              state_r;
    logic [CNT_W-1:0]       waitCnt_r;
    logic [`WORD_LEN-1:0]   capAddr_r;
    logic                   reqReady_r;
    logic                   rspValid_r;
    logic [`WORD_LEN-1:0]   rspInstr_r;
    logic [`WORD_LEN-1:0]   rspAddr_r;
    logic                   rspErr_r;

    logic                   reqErr_s;
    logic [ADDR_W-1:0]      romIdx_s;
    logic [`WORD_LEN-1:0]   romData_s;

    // Storage array: preload writes, asynchronous read at romIdx_s.
    inst_rom #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_rom (
        .clk    (clk),
        .wrEn   (ld_en),
        .wrAddr (ld_addr),
        .wrData (ld_data),
        .rdAddr (romIdx_s),
        .rdData (romData_s)
    );

    // Error classification of the incoming request address.
    always_comb begin
        reqErr_s = addrErr(req_addr, DEPTH);
    end

    // Read index: the live request address while idle (zero-wait and error
    // paths load the response straight from it), the captured one otherwise.
    always_comb begin
        romIdx_s = capAddr_r[ADDR_W+1:2];
        if (state_r == ST_IDLE) begin
            romIdx_s = req_addr[ADDR_W+1:2];
        end else begin
            romIdx_s = capAddr_r[ADDR_W+1:2];
        end
    end

    // Responder FSM with wait counter and registered handshake outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            waitCnt_r  <= {CNT_W{1'b0}};
            capAddr_r  <= {`WORD_LEN{1'b0}};
            reqReady_r <= 1'b1;
            rspValid_r <= 1'b0;
            rspInstr_r <= {`WORD_LEN{1'b0}};
            rspAddr_r  <= {`WORD_LEN{1'b0}};
            rspErr_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // flush wins over a coincident request.
                    if (req_valid && !flush) begin
                        capAddr_r  <= req_addr;
                        reqReady_r <= 1'b0;
                        if (reqErr_s || (WAIT_STATES == 32'd0)) begin
                            // Faulting fetches skip the wait states entirely.
                            state_r    <= ST_RESP;
                            rspValid_r <= 1'b1;
                            rspInstr_r <= reqErr_s ? ERR_INSTR : romData_s;
                            rspAddr_r  <= req_addr;
                            rspErr_r   <= reqErr_s;
                        end else begin
                            state_r   <= ST_WAIT;
                            waitCnt_r <= CNT_W'(WAIT_STATES);
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end

                ST_WAIT: begin
                    if (flush) begin
                        state_r    <= ST_IDLE;
                        waitCnt_r  <= {CNT_W{1'b0}};
                        reqReady_r <= 1'b1;
                    end else if (waitCnt_r == CNT_W'(1'b1)) begin
                        // Only error-free requests ever pass through WAIT.
                        state_r    <= ST_RESP;
                        waitCnt_r  <= {CNT_W{1'b0}};
                        rspValid_r <= 1'b1;
                        rspInstr_r <= romData_s;
                        rspAddr_r  <= capAddr_r;
                        rspErr_r   <= 1'b0;
                    end else begin
                        waitCnt_r <= waitCnt_r - CNT_W'(1'b1);
                    end
                end

                ST_RESP: begin
                    // Response data registers are left untouched on exit;
                    // only rsp_valid qualifies them.
                    if (flush || rsp_ready) begin
                        state_r    <= ST_IDLE;
                        rspValid_r <= 1'b0;
                        reqReady_r <= 1'b1;
                    end else begin
                        state_r <= ST_RESP;
                    end
                end

                default: begin
                    // Illegal encoding: fall back to a clean idle state.
                    state_r    <= ST_IDLE;
                    waitCnt_r  <= {CNT_W{1'b0}};
                    reqReady_r <= 1'b1;
                    rspValid_r <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = reqReady_r;
    assign rsp_valid = rspValid_r;
    assign rsp_instr = rspInstr_r;
    assign rsp_addr  = rspAddr_r;
    assign rsp_err   = rspErr_r;

endmodule : inst_mem_responder

// File: tb/tb_inst_mem_responder.sv
module tb_inst_mem_responder;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        rsp_ready;
    logic        ld_en;
    logic [7:0]  ld_addr;
    logic [31:0] ld_data;

    // DUT "a": WAIT_STATES = 2
    logic        a_req_valid, a_req_ready, a_rsp_valid, a_rsp_err;
    logic [31:0] a_req_addr, a_rsp_instr, a_rsp_addr;
    // DUT "z": WAIT_STATES = 0
    logic        z_req_valid, z_req_ready, z_rsp_valid, z_rsp_err;
    logic [31:0] z_req_addr, z_rsp_instr, z_rsp_addr;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        err;
    } rsp_t;

    rsp_t        qA[$];
    rsp_t        qZ[$];
    logic [31:0] modelMem [256];
    int          nVec = 0;
    int          nMis = 0;

    inst_mem_responder #(.DEPTH(256), .WAIT_STATES(2)) u_dut_a (
        .clk(clk), .rst(rst), .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_addr(a_req_addr), .flush(flush), .rsp_valid(a_rsp_valid),
        .rsp_ready(rsp_ready), .rsp_instr(a_rsp_instr), .rsp_addr(a_rsp_addr),
        .rsp_err(a_rsp_err), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    inst_mem_responder #(.DEPTH(256), .WAIT_STATES(0)) u_dut_z (
        .clk(clk), .rst(rst), .req_valid(z_req_valid), .req_ready(z_req_ready),
        .req_addr(z_req_addr), .flush(flush), .rsp_valid(z_rsp_valid),
        .rsp_ready(rsp_ready), .rsp_instr(z_rsp_instr), .rsp_addr(z_rsp_addr),
        .rsp_err(z_rsp_err), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nMis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic rsp_t expRsp(input logic [31:0] addr);
        rsp_t r;
        logic e;
        e = (addr[1:0] != 2'b00) || (addr[31:2] >= 30'd256);
        r.addr  = addr;
        r.err   = e;
        r.instr = e ? 32'h0 : modelMem[addr[9:2]];
        return r;
    endfunction

    task automatic preload(input logic [7:0] idx, input logic [31:0] d);
        ld_en   = 1'b1;
        ld_addr = idx;
        ld_data = d;
        tick();
        ld_en = 1'b0;
        modelMem[idx] = d;
    endtask

    task automatic waitAValid(input string tag);
        int n;
        n = 0;
        while (a_rsp_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checkVal(tag, 32'(a_rsp_valid === 1'b1), 32'd1);
    endtask

    // Scoreboard for DUT a: compare every delivered response.
    always @(negedge clk) begin
        if (rst === 1'b1 && a_rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            checkVal("a_rsp_expected", 32'(qA.size() != 0), 32'd1);
            if (qA.size() != 0) begin
                rsp_t e;
                e = qA.pop_front();
                checkVal("a_rsp_instr", a_rsp_instr, e.instr);
                checkVal("a_rsp_addr", a_rsp_addr, e.addr);
                checkVal("a_rsp_err", 32'(a_rsp_err), 32'(e.err));
            end
        end
    end

    // Scoreboard for DUT z.
    always @(negedge clk) begin
        if (rst === 1'b1 && z_rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            checkVal("z_rsp_expected", 32'(qZ.size() != 0), 32'd1);
            if (qZ.size() != 0) begin
                rsp_t e;
                e = qZ.pop_front();
                checkVal("z_rsp_instr", z_rsp_instr, e.instr);
                checkVal("z_rsp_addr", z_rsp_addr, e.addr);
                checkVal("z_rsp_err", 32'(z_rsp_err), 32'(e.err));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; flush = 1'b0; rsp_ready = 1'b1;
        ld_en = 1'b0; ld_addr = 8'd0; ld_data = 32'd0;
        a_req_valid = 1'b0; a_req_addr = 32'd0;
        z_req_valid = 1'b0; z_req_addr = 32'd0;
        tick();

        // Reset values
        checkVal("rst_req_ready", 32'(a_req_ready), 32'd1);
        checkVal("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
        checkVal("rst_rsp_instr", a_rsp_instr, 32'd0);
        checkVal("rst_rsp_addr", a_rsp_addr, 32'd0);
        checkVal("rst_rsp_err", 32'(a_rsp_err), 32'd0);
        checkVal("rst_z_req_ready", 32'(z_req_ready), 32'd1);

        // Preload during reset: storage is not affected by reset
        for (int i = 0; i < 16; i++) begin
            preload(8'(i), 32'hA500_0000 + 32'(i) * 32'h0001_0203);
        end
        preload(8'd3, 32'hE3A01005);
        rst = 1'b1;
        tick();
        tick();

        // Basic fetch with latency check
        a_req_addr = 32'h0C; a_req_valid = 1'b1; qA.push_back(expRsp(32'h0C));
        tick(); a_req_valid = 1'b0;
        checkVal("lat_e1_valid", 32'(a_rsp_valid), 32'd0);
        checkVal("lat_e1_ready", 32'(a_req_ready), 32'd0);
        tick();
        checkVal("lat_e2_valid", 32'(a_rsp_valid), 32'd0);
        tick();
        checkVal("lat_e3_valid", 32'(a_rsp_valid), 32'd1);
        checkVal("basic_instr", a_rsp_instr, 32'hE3A01005);
        tick();
        checkVal("basic_idle_ready", 32'(a_req_ready), 32'd1);
        checkVal("basic_valid_drop", 32'(a_rsp_valid), 32'd0);

        // Backpressure
        rsp_ready = 1'b0;
        a_req_addr = 32'h0C; a_req_valid = 1'b1; qA.push_back(expRsp(32'h0C));
        tick(); a_req_valid = 1'b0;
        tick(); tick();
        for (int c = 0; c < 5; c++) begin
            checkVal("bp_valid", 32'(a_rsp_valid), 32'd1);
            checkVal("bp_instr", a_rsp_instr, 32'hE3A01005);
            checkVal("bp_addr", a_rsp_addr, 32'h0C);
            checkVal("bp_err", 32'(a_rsp_err), 32'd0);
            checkVal("bp_req_ready", 32'(a_req_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        checkVal("bp_release_ready", 32'(a_req_ready), 32'd1);
        checkVal("bp_release_valid", 32'(a_rsp_valid), 32'd0);

        // Errors: misaligned and out of range, response on the next edge
        a_req_addr = 32'h0E; a_req_valid = 1'b1; qA.push_back(expRsp(32'h0E));
        tick(); a_req_valid = 1'b0;
        checkVal("err_mis_valid", 32'(a_rsp_valid), 32'd1);
        checkVal("err_mis_err", 32'(a_rsp_err), 32'd1);
        checkVal("err_mis_instr", a_rsp_instr, 32'd0);
        tick();
        a_req_addr = 32'h400; a_req_valid = 1'b1; qA.push_back(expRsp(32'h400));
        tick(); a_req_valid = 1'b0;
        checkVal("err_oor_valid", 32'(a_rsp_valid), 32'd1);
        checkVal("err_oor_err", 32'(a_rsp_err), 32'd1);
        tick();

        // Flush during WAIT: request dropped, no response
        a_req_addr = 32'h04; a_req_valid = 1'b1;
        tick(); a_req_valid = 1'b0;
        flush = 1'b1;
        tick(); flush = 1'b0;
        checkVal("flush_ready", 32'(a_req_ready), 32'd1);
        checkVal("flush_valid", 32'(a_rsp_valid), 32'd0);
        for (int c = 0; c < 4; c++) begin
            tick();
            checkVal("flush_no_rsp", 32'(a_rsp_valid), 32'd0);
        end

        // Flush in IDLE blocks a coincident request
        a_req_addr = 32'h08; a_req_valid = 1'b1; flush = 1'b1;
        tick(); a_req_valid = 1'b0; flush = 1'b0;
        checkVal("flush_idle_ready", 32'(a_req_ready), 32'd1);
        tick();
        checkVal("flush_idle_novalid", 32'(a_rsp_valid), 32'd0);

        // Normal fetch after flush
        a_req_addr = 32'h00; a_req_valid = 1'b1; qA.push_back(expRsp(32'h00));
        tick(); a_req_valid = 1'b0;
        waitAValid("flush_follow_valid");
        tick();

        // Zero-wait back-to-back with req_valid held high
        z_req_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            z_req_addr = 32'(k * 4);
            qZ.push_back(expRsp(z_req_addr));
            tick();
            checkVal("z_valid_on", 32'(z_rsp_valid), 32'd1);
            tick();
            checkVal("z_valid_off", 32'(z_rsp_valid), 32'd0);
            checkVal("z_ready_back", 32'(z_req_ready), 32'd1);
        end
        z_req_valid = 1'b0;
        tick();

        // Write collision: fetch samples word 3 on the same edge it is written
        z_req_addr = 32'h0C; z_req_valid = 1'b1; qZ.push_back(expRsp(32'h0C));
        ld_en = 1'b1; ld_addr = 8'd3; ld_data = 32'h1234_5678;
        tick(); z_req_valid = 1'b0; ld_en = 1'b0;
        modelMem[3] = 32'h1234_5678;
        checkVal("coll_old", z_rsp_instr, 32'hE3A01005);
        tick();
        z_req_addr = 32'h0C; z_req_valid = 1'b1; qZ.push_back(expRsp(32'h0C));
        tick(); z_req_valid = 1'b0;
        checkVal("coll_new", z_rsp_instr, 32'h1234_5678);
        tick();

        // Reset asserted during RESP: outputs clear immediately
        rsp_ready = 1'b0;
        a_req_addr = 32'h08; a_req_valid = 1'b1;
        tick(); a_req_valid = 1'b0;
        tick(); tick();
        checkVal("prerst_valid", 32'(a_rsp_valid), 32'd1);
        #2 rst = 1'b0;
        #1;
        checkVal("midrst_valid", 32'(a_rsp_valid), 32'd0);
        checkVal("midrst_ready", 32'(a_req_ready), 32'd1);
        checkVal("midrst_instr", a_rsp_instr, 32'd0);
        checkVal("midrst_addr", a_rsp_addr, 32'd0);
        checkVal("midrst_err", 32'(a_rsp_err), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        rsp_ready = 1'b1;
        tick();

        // Memory survives reset
        a_req_addr = 32'h04; a_req_valid = 1'b1; qA.push_back(expRsp(32'h04));
        tick(); a_req_valid = 1'b0;
        waitAValid("postrst_valid");
        tick();

        repeat (3) tick();
        checkVal("qA_drained", 32'(qA.size()), 32'd0);
        checkVal("qZ_drained", 32'(qZ.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule : tb_inst_mem_responder
